// File: rtl/multicycle_control_unity.sv
// multicycle_control_unity: multi-cycle RV32I control sequencer.
// Walks FETCH/DECODE/EXEC/MEM/WB, latches opcode/funct3/funct7 once per
// instruction and drives the datapath controls from the current state.
// Optional feature macro: CONTROL_UNITY_TRAP_EN adds a TRAP state and the
// illegal_instr port; without it unknown opcodes retire as a NOP.
module multicycle_control_unity #(
    parameter int ALU_CTRL_W  = 4,
    parameter int DATABUS_W   = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  ir_w_enable,
    output logic                  pc_w_enable,
    output logic                  register_w_enable,
    output logic                  imm_rd,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_mux_in,
    output logic                  alu_mux_out,
    output logic                  ram_w_enable,
    output logic                  br_mux_inv,
    output logic                  br_enable,
    output logic [DATABUS_W-1:0]  databus,
`ifdef CONTROL_UNITY_TRAP_EN
    output logic                  illegal_instr,
`endif
    output logic                  mem_timeout
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef CONTROL_UNITY_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         opcode_q, opcode_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [6:0]         funct7_q, funct7_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_r, is_i, is_l, is_s, is_b, is_lui;
    logic               use_imm;
    logic               timeout_hit;
    logic [3:0]         alu_op;
    logic               unused_f7;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_L) ||
               (op == OP_S) || (op == OP_B) || (op == OP_LUI);
    endfunction

    assign is_r    = (opcode_q == OP_R);
    assign is_i    = (opcode_q == OP_I);
    assign is_l    = (opcode_q == OP_L);
    assign is_s    = (opcode_q == OP_S);
    assign is_b    = (opcode_q == OP_B);
    assign is_lui  = (opcode_q == OP_LUI);
    assign use_imm = is_i || is_l || is_s || is_lui;

    // Only funct7[5] selects an ALU variant; the remaining bits are latched but unused.
    assign unused_f7 = ^{funct7_q[6], funct7_q[4:0]};

    // ALU operation for the latched instruction (loads/stores/unknown default to add).
    always_comb begin
        alu_op = 4'b0000;
        if (is_r) begin
            alu_op = {funct7_q[5], funct3_q};
        end else if (is_i) begin
            alu_op = {(funct3_q == 3'b101) ? funct7_q[5] : 1'b0, funct3_q};
        end else if (is_b) begin
            case (funct3_q[2:1])
                2'b00:   alu_op = 4'b1000;
                2'b10:   alu_op = 4'b0010;
                2'b11:   alu_op = 4'b0011;
                default: alu_op = 4'b0000;
            endcase
        end else if (is_lui) begin
            alu_op = 4'b1111;
        end
    end

    // Next-state and per-state controls; everything is forced to 0 while rst is high.
    always_comb begin
        state_d           = state_q;
        opcode_d          = opcode_q;
        funct3_d          = funct3_q;
        funct7_d          = funct7_q;
        cnt_d             = cnt_q;
        timeout_hit       = 1'b0;
        mem_req           = 1'b0;
        ir_w_enable       = 1'b0;
        pc_w_enable       = 1'b0;
        register_w_enable = 1'b0;
        imm_rd            = 1'b0;
        alu_control       = '0;
        alu_mux_in        = 1'b0;
        alu_mux_out       = 1'b0;
        ram_w_enable      = 1'b0;
        br_mux_inv        = 1'b0;
        br_enable         = 1'b0;
        databus           = '0;
        mem_timeout       = 1'b0;
`ifdef CONTROL_UNITY_TRAP_EN
        illegal_instr     = 1'b0;
`endif
        if (!rst) begin
            timeout_hit = (MEM_TIMEOUT != 0) &&
                          ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                          (cnt_q == CNT_W'(MEM_TIMEOUT));
            if (timeout_hit) begin
                mem_timeout = 1'b1;
                state_d     = S_FETCH;
            end else begin
                unique case (state_q)
                    S_FETCH: begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_w_enable = 1'b1;
                            state_d     = S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        opcode_d = opcode;
                        funct3_d = funct3;
                        funct7_d = funct7;
`ifdef CONTROL_UNITY_TRAP_EN
                        state_d  = op_known(opcode) ? S_EXEC : S_TRAP;
`else
                        state_d  = S_EXEC;
`endif
                    end
                    S_EXEC: begin
                        alu_control = ALU_CTRL_W'(alu_op);
                        imm_rd      = use_imm;
                        alu_mux_in  = use_imm;
                        if (is_b) begin
                            br_enable   = 1'b1;
                            br_mux_inv  = funct3_q[0];
                            pc_w_enable = 1'b1;
                            state_d     = S_FETCH;
                        end else if (is_l || is_s) begin
                            state_d = S_MEM;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    S_MEM: begin
                        mem_req      = 1'b1;
                        ram_w_enable = is_s;
                        databus      = DATABUS_W'(funct3_q);
                        if (mem_ready) begin
                            pc_w_enable = is_s;
                            state_d     = is_s ? S_FETCH : S_WB;
                        end
                    end
                    S_WB: begin
                        register_w_enable = op_known(opcode_q);
                        pc_w_enable       = 1'b1;
                        alu_mux_out       = is_l;
                        if (is_l) databus = DATABUS_W'(funct3_q);
                        state_d           = S_FETCH;
                    end
`ifdef CONTROL_UNITY_TRAP_EN
                    S_TRAP: begin
                        illegal_instr = 1'b1;
                    end
`endif
                    default: state_d = S_FETCH;
                endcase
            end
            if ((state_d != state_q) || timeout_hit) begin
                cnt_d = '0;
            end else if (mem_req && !mem_ready) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, latched instruction fields and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unity.sv
// tb_multicycle_control_unity: scoreboard bench for multicycle_control_unity.
// Each driven cycle pushes its expected output vector; a negedge monitor pops
// and compares it against the DUT outputs.
module tb_multicycle_control_unity;

    localparam int TMO   = 16;
    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_NOP = 4;

    typedef struct packed {
        logic       mem_req;
        logic       ir_w;
        logic       pc_w;
        logic       reg_w;
        logic       imm_rd;
        logic [3:0] alu;
        logic       mux_in;
        logic       mux_out;
        logic       ram_w;
        logic       br_inv;
        logic       br_en;
        logic [2:0] db;
        logic       tmo;
    } vec_t;

    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_ready;
    logic       mem_req;
    logic       ir_w_enable;
    logic       pc_w_enable;
    logic       register_w_enable;
    logic       imm_rd;
    logic [3:0] alu_control;
    logic       alu_mux_in;
    logic       alu_mux_out;
    logic       ram_w_enable;
    logic       br_mux_inv;
    logic       br_enable;
    logic [2:0] databus;
    logic       mem_timeout;
`ifdef CONTROL_UNITY_TRAP_EN
    logic       illegal_instr;
`endif

    logic [17:0] obs_bits;
    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;

    multicycle_control_unity dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .funct3            (funct3),
        .funct7            (funct7),
        .mem_ready         (mem_ready),
        .mem_req           (mem_req),
        .ir_w_enable       (ir_w_enable),
        .pc_w_enable       (pc_w_enable),
        .register_w_enable (register_w_enable),
        .imm_rd            (imm_rd),
        .alu_control       (alu_control),
        .alu_mux_in        (alu_mux_in),
        .alu_mux_out       (alu_mux_out),
        .ram_w_enable      (ram_w_enable),
        .br_mux_inv        (br_mux_inv),
        .br_enable         (br_enable),
        .databus           (databus),
`ifdef CONTROL_UNITY_TRAP_EN
        .illegal_instr     (illegal_instr),
`endif
        .mem_timeout       (mem_timeout)
    );

    assign obs_bits = {mem_req, ir_w_enable, pc_w_enable, register_w_enable, imm_rd,
                       alu_control, alu_mux_in, alu_mux_out, ram_w_enable,
                       br_mux_inv, br_enable, databus, mem_timeout};

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare the expected vector of the current cycle at negedge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, 32'(obs_bits), 32'(e.v));
        end
    end

    // Drive mem_ready for one cycle and record what the outputs must be in it.
    task automatic stepCycle(input logic rdy, input string tag, input vec_t v);
        exp_t e;
        mem_ready = rdy;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // FETCH (optionally through one timeout), DECODE with IR scrambled afterwards, then EXEC.
    task automatic frontHalf(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fwait, input int kind,
                             input logic [3:0] ealu, input logic eimm);
        vec_t v;
        int   nw;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        nw = (fwait >= TMO) ? TMO : fwait;
        for (int i = 0; i < nw; i++) begin
            v = '0; v.mem_req = 1'b1;
            stepCycle(1'b0, {name, ".fwait"}, v);
        end
        if (fwait >= TMO) begin
            v = '0; v.tmo = 1'b1;
            stepCycle(1'b0, {name, ".ftmo"}, v);
        end
        v = '0; v.mem_req = 1'b1; v.ir_w = 1'b1;
        stepCycle(1'b1, {name, ".fetch"}, v);
        v = '0;
        stepCycle(1'b1, {name, ".dec"}, v);
        opcode = ~op;
        funct3 = ~f3;
        funct7 = ~f7;
        v = '0; v.alu = ealu; v.imm_rd = eimm; v.mux_in = eimm;
        if (kind == K_BR) begin
            v.br_en = 1'b1; v.br_inv = f3[0]; v.pc_w = 1'b1;
        end
        stepCycle(1'b1, {name, ".exec"}, v);
    endtask

    // One full instruction; mwait >= TMO makes the MEM access time out.
    task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input int fwait, input int mwait,
                                 input int kind, input logic [3:0] ealu, input logic eimm,
                                 input logic [2:0] edb);
        vec_t v;
        int   nw;
        frontHalf(name, op, f3, f7, fwait, kind, ealu, eimm);
        if (kind == K_LD || kind == K_ST) begin
            nw = (mwait >= TMO) ? TMO : mwait;
            for (int i = 0; i < nw; i++) begin
                v = '0; v.mem_req = 1'b1; v.ram_w = (kind == K_ST); v.db = edb;
                stepCycle(1'b0, {name, ".mwait"}, v);
            end
            if (mwait >= TMO) begin
                v = '0; v.tmo = 1'b1;
                stepCycle(1'b0, {name, ".mtmo"}, v);
                return;
            end
            v = '0; v.mem_req = 1'b1; v.ram_w = (kind == K_ST); v.db = edb;
            v.pc_w = (kind == K_ST);
            stepCycle(1'b1, {name, ".mem"}, v);
        end
        if (kind == K_ALU || kind == K_LD || kind == K_NOP) begin
            v = '0; v.reg_w = (kind != K_NOP); v.pc_w = 1'b1;
            v.mux_out = (kind == K_LD);
            v.db = (kind == K_LD) ? edb : 3'b000;
            stepCycle(1'b1, {name, ".wb"}, v);
        end
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        vec_t v;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 7'b0;
        funct3    = 3'b0;
        funct7    = 7'b0;
        #3;
        checkOutput("reset", 32'(obs_bits), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus("srl",   7'b0110011, 3'b101, 7'b0000000, 0, 0, K_ALU, 4'b0101, 1'b0, 3'b000);
        applyStimulus("sra",   7'b0110011, 3'b101, 7'b0100000, 2, 0, K_ALU, 4'b1101, 1'b0, 3'b000);
        applyStimulus("addi",  7'b0010011, 3'b000, 7'b0100000, 0, 0, K_ALU, 4'b0000, 1'b1, 3'b000);
        applyStimulus("srai",  7'b0010011, 3'b101, 7'b0100000, 1, 0, K_ALU, 4'b1101, 1'b1, 3'b000);
        applyStimulus("lb",    7'b0000011, 3'b000, 7'b0000000, 0, 3, K_LD,  4'b0000, 1'b1, 3'b000);
        applyStimulus("lhu",   7'b0000011, 3'b101, 7'b0000000, 0, 0, K_LD,  4'b0000, 1'b1, 3'b101);
        applyStimulus("sw",    7'b0100011, 3'b010, 7'b0000000, 0, 1, K_ST,  4'b0000, 1'b1, 3'b010);
        applyStimulus("bne",   7'b1100011, 3'b001, 7'b0000000, 0, 0, K_BR,  4'b1000, 1'b0, 3'b000);
        applyStimulus("bge",   7'b1100011, 3'b101, 7'b0000000, 0, 0, K_BR,  4'b0010, 1'b0, 3'b000);
        applyStimulus("bltu",  7'b1100011, 3'b110, 7'b0000000, 0, 0, K_BR,  4'b0011, 1'b0, 3'b000);
        applyStimulus("lui",   7'b0110111, 3'b011, 7'b1111111, 0, 0, K_ALU, 4'b1111, 1'b1, 3'b000);
        applyStimulus("ftmo",  7'b0110011, 3'b000, 7'b0000000, TMO, 0, K_ALU, 4'b0000, 1'b0, 3'b000);
        applyStimulus("f15",   7'b0110011, 3'b111, 7'b0000000, TMO - 1, 0, K_ALU, 4'b0111, 1'b0, 3'b000);
        applyStimulus("lw15",  7'b0000011, 3'b010, 7'b0000000, 0, TMO - 1, K_LD, 4'b0000, 1'b1, 3'b010);
        applyStimulus("lwtmo", 7'b0000011, 3'b010, 7'b0000000, 0, TMO, K_LD, 4'b0000, 1'b1, 3'b010);
        applyStimulus("swtmo", 7'b0100011, 3'b001, 7'b0000000, 0, TMO, K_ST, 4'b0000, 1'b1, 3'b001);
        applyStimulus("after", 7'b0110011, 3'b100, 7'b0000000, 0, 0, K_ALU, 4'b0100, 1'b0, 3'b000);

        // Reset asserted in the middle of a store's MEM state.
        frontHalf("swrst", 7'b0100011, 3'b000, 7'b0000000, 0, K_ST, 4'b0000, 1'b1);
        mem_ready = 1'b0;
        #1;
        v = '0; v.mem_req = 1'b1; v.ram_w = 1'b1; v.db = 3'b000;
        checkOutput("swrst.mem", 32'(obs_bits), 32'(v));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("swrst.async", 32'(obs_bits), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("postrst", 7'b0110011, 3'b001, 7'b0000000, 0, 0, K_ALU, 4'b0001, 1'b0, 3'b000);

`ifdef CONTROL_UNITY_TRAP_EN
        // Unknown opcode traps and holds illegal_instr until reset.
        opcode = 7'b1111111;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        v = '0; v.mem_req = 1'b1; v.ir_w = 1'b1;
        stepCycle(1'b1, "trap.fetch", v);
        v = '0;
        stepCycle(1'b1, "trap.dec", v);
        for (int i = 0; i < 4; i++) begin
            checkOutput("trap.illegal", 32'(illegal_instr), 32'd1);
            v = '0;
            stepCycle(1'b1, "trap.hold", v);
        end
        rst = 1'b1;
        #1;
        checkOutput("trap.rst", 32'(illegal_instr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("posttrap", 7'b0110011, 3'b000, 7'b0000000, 0, 0, K_ALU, 4'b0000, 1'b0, 3'b000);
`else
        applyStimulus("nop",   7'b1111111, 3'b000, 7'b0000000, 0, 0, K_NOP, 4'b0000, 1'b0, 3'b000);
        applyStimulus("postnop", 7'b0010011, 3'b111, 7'b0000000, 0, 0, K_ALU, 4'b0111, 1'b1, 3'b000);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
